// File: rtl/rng_pkg.sv
// Shared definitions for the enable-interval counter and its per-channel slices.
package rng_pkg;

   // Counter overflow behaviour selectors for the SATURATE parameter.
   localparam int unsigned CNT_WRAP = 0;
   localparam int unsigned CNT_SAT  = 1;

   // Width of a channel index; a single channel still needs a 1-bit field.
   function automatic int unsigned chan_idx_width(input int unsigned channels);
      return (channels > 1) ? int'($clog2(channels)) : 1;
   endfunction

endpackage

// File: rtl/interval_counter_channel.sv
// One measurement channel: counts enable-high cycles, captures the length on the
// falling edge into a single-entry holding slot, and flags captures it had to drop.
module interval_counter_channel
   import rng_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned SATURATE = CNT_WRAP
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             enable_i,
   input  logic             clear_ovf_i,
   input  logic             grant_i,
   output logic             pending_o,
   output logic [WIDTH-1:0] hold_o,
   output logic             overflow_o
);

   localparam logic [WIDTH-1:0] CntOne = {{(WIDTH-1){1'b0}}, 1'b1};

   logic             last_en_q, last_en_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             pending_q, pending_d;
   logic             overflow_q, overflow_d;
   logic             fall;

   assign fall = last_en_q & ~enable_i;

   // Next-state for counter, holding slot and sticky overflow.
   always_comb begin
      last_en_d  = enable_i;
      cnt_d      = cnt_q;
      hold_d     = hold_q;
      pending_d  = pending_q;
      overflow_d = overflow_q & ~clear_ovf_i;

      if (enable_i) begin
         if (!last_en_q) begin
            cnt_d = CntOne;
         end else if ((SATURATE == CNT_SAT) && (cnt_q == '1)) begin
            cnt_d = cnt_q;
         end else begin
            cnt_d = cnt_q + CntOne;
         end
      end

      // A grant empties the slot this cycle, so a coincident capture still fits.
      if (grant_i) begin
         pending_d = 1'b0;
      end

      if (fall) begin
         if (!pending_q || grant_i) begin
            hold_d    = cnt_q;
            pending_d = 1'b1;
         end else begin
            overflow_d = 1'b1;
         end
      end
   end

   // Channel state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_en_q  <= 1'b0;
         cnt_q      <= '0;
         hold_q     <= '0;
         pending_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         last_en_q  <= last_en_d;
         cnt_q      <= cnt_d;
         hold_q     <= hold_d;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
      end
   end

   assign pending_o  = pending_q;
   assign hold_o     = hold_q;
   assign overflow_o = overflow_q;

endmodule

// File: rtl/enable_interval_counter.sv
// Multi-channel enable-interval counter: per-channel captures merged into one
// valid/ready stream by a round-robin arbiter feeding a single output register.
module enable_interval_counter
   import rng_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned SATURATE = CNT_WRAP
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic [CHANNELS-1:0]                   enable_i,
   input  logic [CHANNELS-1:0]                   clear_ovf_i,
   input  logic                                  out_ready_i,
   output logic                                  out_valid_o,
   output logic [WIDTH-1:0]                      out_data_o,
   output logic [chan_idx_width(CHANNELS)-1:0]   out_channel_o,
   output logic [CHANNELS-1:0]                   overflow_o
);

   localparam int unsigned IDXW = chan_idx_width(CHANNELS);

   logic [CHANNELS-1:0] pending;
   logic [CHANNELS-1:0] grant;
   logic [WIDTH-1:0]    hold [CHANNELS];

   logic [IDXW-1:0]  ptr_q, ptr_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [IDXW-1:0]  out_channel_q, out_channel_d;

   logic             load_en;
   logic             found;
   logic [IDXW-1:0]  gnt_idx;
   logic [WIDTH-1:0] sel_data;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      interval_counter_channel #(
         .WIDTH    (WIDTH),
         .SATURATE (SATURATE)
      ) u_chan (
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
         .enable_i    (enable_i[c]),
         .clear_ovf_i (clear_ovf_i[c]),
         .grant_i     (grant[c]),
         .pending_o   (pending[c]),
         .hold_o      (hold[c]),
         .overflow_o  (overflow_o[c])
      );
   end

   assign load_en = ~out_valid_q | out_ready_i;

   // Round-robin pick: first pending channel at/after the pointer, then wrap to below it.
   always_comb begin
      found    = 1'b0;
      gnt_idx  = '0;
      sel_data = '0;
      grant    = '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         if (!found && pending[c] && (IDXW'(c) >= ptr_q)) begin
            found   = 1'b1;
            gnt_idx = IDXW'(c);
         end
      end
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         if (!found && pending[c] && (IDXW'(c) < ptr_q)) begin
            found   = 1'b1;
            gnt_idx = IDXW'(c);
         end
      end
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         if (gnt_idx == IDXW'(c)) begin
            sel_data = hold[c];
            grant[c] = load_en & found;
         end
      end
   end

   // Output stage and pointer next-state.
   always_comb begin
      out_valid_d   = out_valid_q;
      out_data_d    = out_data_q;
      out_channel_d = out_channel_q;
      ptr_d         = ptr_q;
      if (load_en) begin
         out_valid_d = found;
         if (found) begin
            out_data_d    = sel_data;
            out_channel_d = gnt_idx;
            ptr_d         = (gnt_idx == IDXW'(CHANNELS - 1)) ? '0 : gnt_idx + IDXW'(1);
         end
      end
   end

   // Output register and arbiter pointer.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_channel_q <= '0;
         ptr_q         <= '0;
      end else begin
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         out_channel_q <= out_channel_d;
         ptr_q         <= ptr_d;
      end
   end

   assign out_valid_o   = out_valid_q;
   assign out_data_o    = out_data_q;
   assign out_channel_o = out_channel_q;

endmodule

// File: tb/tb_enable_interval_counter.sv
// Self-checking bench: directed table, hand-written corner sequences and a random
// run against a run-length reference model.
module tb_enable_interval_counter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  en, clr;
   logic        rdy;
   logic        ov;
   logic [31:0] od;
   logic [1:0]  oc;
   logic [3:0]  ovf;

   logic        wv, sv, wc, sc, wo, so;
   logic [3:0]  wd, sd;

   always #5 clk = ~clk;

   enable_interval_counter #(.WIDTH(32), .CHANNELS(4), .SATURATE(0)) dut (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .clear_ovf_i(clr), .out_ready_i(rdy),
      .out_valid_o(ov), .out_data_o(od), .out_channel_o(oc), .overflow_o(ovf)
   );

   enable_interval_counter #(.WIDTH(4), .CHANNELS(1), .SATURATE(0)) dut_wrap (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(en[0:0]), .clear_ovf_i(1'b0), .out_ready_i(1'b1),
      .out_valid_o(wv), .out_data_o(wd), .out_channel_o(wc), .overflow_o(wo)
   );

   enable_interval_counter #(.WIDTH(4), .CHANNELS(1), .SATURATE(1)) dut_sat (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(en[0:0]), .clear_ovf_i(1'b0), .out_ready_i(1'b1),
      .out_valid_o(sv), .out_data_o(sd), .out_channel_o(sc), .overflow_o(so)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: run lengths as plain integers, one slot per channel.
   int unsigned m_run [4];
   bit          m_last[4];
   bit          m_pend[4];
   int unsigned m_hold[4];
   logic [3:0]  m_ovf;
   bit          m_v;
   int unsigned m_d;
   int          m_c;
   int          m_ptr;

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_run[i] = 0; m_last[i] = 0; m_pend[i] = 0; m_hold[i] = 0;
      end
      m_ovf = '0; m_v = 0; m_d = 0; m_c = 0; m_ptr = 0;
   endtask

   task automatic model_step();
      bit load;
      int g;
      load = !m_v || rdy;
      g = -1;
      for (int k = 0; k < 4; k++) begin
         if (g < 0 && m_pend[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      end
      if (load) begin
         if (g >= 0) begin
            m_v = 1; m_d = m_hold[g]; m_c = g; m_ptr = (g + 1) % 4; m_pend[g] = 0;
         end else begin
            m_v = 0;
         end
      end
      for (int i = 0; i < 4; i++) begin
         bit drop;
         drop = 0;
         if (m_last[i] && !en[i]) begin
            if (!m_pend[i]) begin
               m_pend[i] = 1; m_hold[i] = m_run[i];
            end else begin
               drop = 1;
            end
         end
         m_ovf[i] = drop || (m_ovf[i] && !clr[i]);
         if (en[i]) m_run[i] = m_last[i] ? m_run[i] + 1 : 1;
         m_last[i] = en[i];
      end
   endtask

   task automatic model_check();
      check("model valid", ov, m_v);
      check("model overflow", ovf, m_ovf);
      if (m_v) begin
         check("model data", od, m_d);
         check("model channel", oc, m_c);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
      #1;
      model_check();
   endtask

   typedef struct {
      logic [3:0]  en;
      logic [3:0]  clr;
      logic        rdy;
      logic        v;
      logic [31:0] d;
      logic [1:0]  c;
      logic [3:0]  ovf;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic [3:0] e, input logic [3:0] cl, input logic r,
                               input logic v, input logic [31:0] d, input logic [1:0] c,
                               input logic [3:0] o);
      vec_t t;
      t.en = e; t.clr = cl; t.rdy = r; t.v = v; t.d = d; t.c = c; t.ovf = o;
      return t;
   endfunction

   // Four windows of lengths 4,3,2,1 on channels 0..3, all falling together.
   task automatic burst(input int first);
      en = 4'b0001; tick();
      en = 4'b0011; tick();
      en = 4'b0111; tick();
      en = 4'b1111; tick();
      en = 4'b0000; tick();
      check("burst latency valid", ov, 1'b0);
      for (int k = 0; k < 4; k++) begin
         int ch;
         ch = (first + k) % 4;
         tick();
         check("burst valid", ov, 1'b1);
         check("burst channel", oc, ch);
         check("burst data", od, 4 - ch);
      end
      tick();
      check("burst drained", ov, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; en = '0; clr = '0; rdy = 1'b1;
      model_reset();
      tick(); tick();
      check("reset valid", ov, 1'b0);
      check("reset data", od, 0);
      check("reset channel", oc, 0);
      check("reset overflow", ovf, 0);
      rst_n = 1'b1;
      tick();

      // Directed table: 5-cycle window on ch0, then a forced drop on ch1.
      for (int i = 0; i < 5; i++) tbl.push_back(mk(4'h1, 4'h0, 1, 0, 0, 0, 4'h0));
      tbl.push_back(mk(4'h0, 4'h0, 1, 0, 0, 0, 4'h0));
      tbl.push_back(mk(4'h0, 4'h0, 1, 1, 5, 0, 4'h0));
      tbl.push_back(mk(4'h0, 4'h0, 1, 0, 0, 0, 4'h0));
      tbl.push_back(mk(4'h1, 4'h0, 0, 0, 0, 0, 4'h0));
      tbl.push_back(mk(4'h0, 4'h0, 0, 0, 0, 0, 4'h0));
      for (int i = 0; i < 3; i++) tbl.push_back(mk(4'h2, 4'h0, 0, 1, 1, 0, 4'h0));
      tbl.push_back(mk(4'h0, 4'h0, 0, 1, 1, 0, 4'h0));
      for (int i = 0; i < 7; i++) tbl.push_back(mk(4'h2, 4'h0, 0, 1, 1, 0, 4'h0));
      tbl.push_back(mk(4'h0, 4'h0, 0, 1, 1, 0, 4'h2));
      tbl.push_back(mk(4'h0, 4'h0, 1, 1, 3, 1, 4'h2));
      tbl.push_back(mk(4'h0, 4'h0, 1, 0, 0, 0, 4'h2));
      tbl.push_back(mk(4'h0, 4'h2, 1, 0, 0, 0, 4'h0));
      tbl.push_back(mk(4'h0, 4'h0, 1, 0, 0, 0, 4'h0));
      foreach (tbl[i]) begin
         en = tbl[i].en; clr = tbl[i].clr; rdy = tbl[i].rdy;
         tick();
         check($sformatf("tbl[%0d] valid", i), ov, tbl[i].v);
         check($sformatf("tbl[%0d] overflow", i), ovf, tbl[i].ovf);
         if (tbl[i].v) begin
            check($sformatf("tbl[%0d] data", i), od, tbl[i].d);
            check($sformatf("tbl[%0d] channel", i), oc, tbl[i].c);
         end
      end
      clr = '0;

      // Single-cycle pulse on ch2: pending after the falling sample, beat one edge later.
      en = 4'b0100; tick();
      check("pulse rise valid", ov, 1'b0);
      en = 4'b0000; tick();
      check("pulse fall valid", ov, 1'b0);
      tick();
      check("pulse valid", ov, 1'b1);
      check("pulse data", od, 1);
      check("pulse channel", oc, 2);
      tick();
      check("pulse drained", ov, 1'b0);

      // Reset in the middle of a ch0 window aborts it without a capture.
      en = 4'b0001; tick(); tick(); tick();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check("async reset valid", ov, 1'b0);
      check("async reset data", od, 0);
      check("async reset channel", oc, 0);
      check("async reset overflow", ovf, 0);
      tick();
      rst_n = 1'b1; en = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("aborted window valid", ov, 1'b0);
      end

      burst(0);
      en = 4'b0001; tick();
      en = 4'b0000; tick(); tick();
      check("ptr pulse channel", oc, 0);
      tick();
      burst(1);

      // WIDTH=4 instances: 18-cycle window wraps to 2 or saturates at 15.
      en = 4'b0001;
      repeat (18) tick();
      en = 4'b0000; tick();
      check("w4 latency wrap valid", wv, 1'b0);
      check("w4 latency sat valid", sv, 1'b0);
      tick();
      check("w4 wrap valid", wv, 1'b1);
      check("w4 wrap data", wd, 2);
      check("w4 sat valid", sv, 1'b1);
      check("w4 sat data", sd, 15);
      tick(); tick();

      // Random traffic against the model.
      for (int n = 0; n < 2000; n++) begin
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 2) == 0) en[b] = ~en[b];
         end
         rdy = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0;
         tick();
      end
      en = '0; clr = '0; rdy = 1'b1;
      repeat (8) tick();
      check("final drained", ov, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
